pixel_frame_ctrl: RTL and testbench
===================================

Name: pixel_frame_ctrl

Overview:
Frame sequencer for the pixel digital array. Each pixel is an SR latch: `r` clears it, and the comparator drives `s` during exposure. Pixel outputs are read through an external 2:1-mux tree selected by `rd_sel`. The block runs the whole frame: clear all latches, time the exposure window, then walk the mux select over every pixel and stream one bit per pixel out on a valid/ready handshake.

Parameters:
- NPIX, 8, number of pixels; must be a power of 2, ≥2.
- SEL_W, 3, mux-select width; must equal log2(NPIX).
- EXP_W, 8, width of exposure-time input.
- CLR_CYC, 2, cycles `pix_r` is held high in CLEAR; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  begin a frame; sampled only in IDLE.
- exp_time  in  EXP_W  exposure length in cycles; latched on accepted start.
- pix_mux_out  in  1  selected pixel `q` from the mux tree.
- pix_r  out  1  drives `r` of all pixel latches.
- pix_s_en  out  1  gates comparator `s` into the latches.
- rd_sel  out  SEL_W  mux-tree select (pixel index).
- out_bit  out  1  pixel value being presented.
- out_valid  out  1  `out_bit` is valid.
- out_ready  in  1  consumer accepts `out_bit`.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- **Reset.** While `reset`=0 at a clock edge, the block enters IDLE. All outputs go to 0, as do `idx`, `timer` and the latched `exp_time`. Reset overrides `start` and takes effect from any state, including mid-exposure or mid-handshake.
- **Output registering.** All outputs are registered and decoded from the state and counters.

States:
- **IDLE.**
  - All outputs 0.
  - `start`=1: latch `exp_time`, load `timer`=CLR_CYC-1, go to CLEAR.
- **CLEAR.**
  - `pix_r`=1 and `busy`=1.
  - Stays exactly CLR_CYC cycles (`timer` decrements to 0).
  - Then: latched `exp_time`=0 → go to SETTLE with `idx`=0, skipping exposure. Otherwise load `timer`=`exp_time`-1 and go to EXPOSE.
- **EXPOSE.**
  - `pix_s_en`=1, `pix_r`=0.
  - Lasts exactly `exp_time` cycles.
  - Then: `idx`=0, go to SETTLE.
- **SETTLE.**
  - `rd_sel`=`idx` and `out_valid`=0 for one cycle, allowing mux propagation.
  - At the end of the cycle, capture `pix_mux_out` into `out_bit` and go to SHIFT.
- **SHIFT.**
  - `out_valid`=1; `out_bit` and `rd_sel` are held stable until the handshake.
  - Handshake is `out_valid` & `out_ready` at a clock edge.
  - On handshake with `idx`=NPIX-1: go to DONE.
  - On handshake otherwise: `idx`+1, go to SETTLE.
  - `out_ready` may be held high continuously, giving 2 cycles per pixel. It may stall indefinitely with no change to outputs.
- **DONE.**
  - `frame_done`=1 for one cycle, `busy`=1.
  - Then go to IDLE.

Boundary conditions:
- `start` while busy is ignored; no queuing.
- `start` held high re-triggers from IDLE on the cycle after DONE.
- Changes to `exp_time` during a frame have no effect.
- `idx` never wraps within a frame.
- Frame length with `out_ready` always 1 = 1 (IDLE) + CLR_CYC + `exp_time` + 2·NPIX + 1 (DONE) cycles.

Decomposition:
- **Package/header `pixel_ctrl_pkg`:** state encodings (IDLE, CLEAR, EXPOSE, SETTLE, SHIFT, DONE; 3-bit binary) and the default NPIX, SEL_W, EXP_W and CLR_CYC values, shared with the array top level and bench.
- **Sub-module `pixel_ctrl_timer`:** loadable EXP_W-bit down-counter with `load`, `load_val` and `zero` outputs, used for both CLEAR and EXPOSE.
- **Not part of this block:** the mux tree stays in the array top level.

Test Plan:
- **Reset and idle:** `reset`=0 for 3 cycles, then 1 with `start`=0 → all outputs 0 and `busy`=0 for 10 cycles.
- **Basic frame:** NPIX=8, `exp_time`=5, `out_ready`=1, external pixel model returns pattern 8'b1011_0010 → `pix_r` high 2 cycles, then `pix_s_en` high 5 cycles. `out_bit` sequence for `idx` 0..7 is 0,1,0,0,1,1,0,1. Bench checks `rd_sel` and `out_bit` on each SHIFT cycle. `frame_done` pulses at cycle 1+2+5+16+1.
- **Backpressure:** `out_ready` toggled randomly, held low 20 cycles on `idx`=3 → `out_bit`, `rd_sel` and `out_valid` stay stable while stalled. Exactly 8 handshakes occur and no bit is lost or duplicated.
- **Zero exposure:** `exp_time`=0 → `pix_s_en` never asserts; SETTLE follows CLEAR directly; 8 bits are read.
- **Start while busy:** `start` pulsed during EXPOSE and SHIFT → no effect. `start` held high → new frame begins the cycle after `frame_done`, using the latest `exp_time`.
- **Mid-frame reset:** `reset`=0 for 1 cycle at `idx`=5 in SHIFT → next cycle all outputs 0 and state IDLE. A following `start` runs a full 8-bit frame from `idx` 0.

Source files
------------

// File: rtl/pixel_ctrl_pkg.sv
// rtl/pixel_ctrl_pkg.sv - shared defaults and state encoding for the pixel frame sequencer
package pixel_ctrl_pkg;

  localparam int DEF_NPIX    = 8;
  localparam int DEF_SEL_W   = 3;
  localparam int DEF_EXP_W   = 8;
  localparam int DEF_CLR_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_EXPOSE = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SHIFT  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/pixel_frame_ctrl_if.sv
// rtl/pixel_frame_ctrl_if.sv - pixel array control, readout and bit-stream signals
interface pixel_frame_ctrl_if
  import pixel_ctrl_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W,
  parameter int EXP_W = DEF_EXP_W
);

  logic             start;
  logic [EXP_W-1:0] exp_time;
  logic             pix_mux_out;
  logic             pix_r;
  logic             pix_s_en;
  logic [SEL_W-1:0] rd_sel;
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             frame_done;

  modport master (
    input  start, exp_time, pix_mux_out, out_ready,
    output pix_r, pix_s_en, rd_sel, out_bit, out_valid, busy, frame_done
  );

  modport slave (
    output start, exp_time, pix_mux_out, out_ready,
    input  pix_r, pix_s_en, rd_sel, out_bit, out_valid, busy, frame_done
  );

endinterface

// File: rtl/pixel_ctrl_timer.sv
// rtl/pixel_ctrl_timer.sv - loadable down-counter that parks at zero
module pixel_ctrl_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/pixel_frame_ctrl.sv
// rtl/pixel_frame_ctrl.sv - frame sequencer: clear, expose, then stream one bit per pixel
module pixel_frame_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int NPIX    = DEF_NPIX,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int EXP_W   = DEF_EXP_W,
  parameter int CLR_CYC = DEF_CLR_CYC
) (
  input logic                clk,
  input logic                reset,
  pixel_frame_ctrl_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  logic [EXP_W-1:0] r_exp;
  logic [SEL_W-1:0] r_idx;
  logic [SEL_W-1:0] w_idx_next;
  logic             w_tmr_load;
  logic [EXP_W-1:0] w_tmr_val;
  logic             w_tmr_zero;
  logic             w_hs;
  logic             w_last;

  logic r_pix_r;
  logic r_pix_s_en;
  logic r_out_bit;
  logic r_out_valid;
  logic r_busy;
  logic r_frame_done;

  pixel_ctrl_timer #(.W(EXP_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .zero     (w_tmr_zero)
  );

  assign w_hs   = (r_state == ST_SHIFT) && bus.out_ready;
  assign w_last = (r_idx == SEL_W'(NPIX - 1));

  always_comb begin
    w_next     = r_state;
    w_idx_next = '0;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next     = ST_CLEAR;
          w_tmr_load = 1'b1;
          w_tmr_val  = EXP_W'(CLR_CYC - 1);
        end
      end
      ST_CLEAR: begin
        if (w_tmr_zero) begin
          if (r_exp == '0) begin
            w_next = ST_SETTLE;
          end else begin
            w_next     = ST_EXPOSE;
            w_tmr_load = 1'b1;
            w_tmr_val  = r_exp - EXP_W'(1);
          end
        end
      end
      ST_EXPOSE: begin
        if (w_tmr_zero) w_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        w_idx_next = r_idx;
        w_next     = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_idx_next = r_idx;
        if (w_hs) begin
          if (w_last) begin
            w_next     = ST_DONE;
            w_idx_next = '0;
          end else begin
            w_next     = ST_SETTLE;
            w_idx_next = r_idx + SEL_W'(1);
          end
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up with r_state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_exp        <= '0;
      r_pix_r      <= 1'b0;
      r_pix_s_en   <= 1'b0;
      r_out_bit    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_idx        <= w_idx_next;
      if (r_state == ST_IDLE && bus.start) r_exp <= bus.exp_time;
      r_pix_r      <= (w_next == ST_CLEAR);
      r_pix_s_en   <= (w_next == ST_EXPOSE);
      r_out_valid  <= (w_next == ST_SHIFT);
      r_busy       <= (w_next != ST_IDLE);
      r_frame_done <= (w_next == ST_DONE);
      if (w_next != ST_SHIFT) begin
        r_out_bit <= 1'b0;
      end else if (r_state == ST_SETTLE) begin
        r_out_bit <= bus.pix_mux_out;
      end
    end
  end

  assign bus.pix_r      = r_pix_r;
  assign bus.pix_s_en   = r_pix_s_en;
  assign bus.rd_sel     = r_idx;
  assign bus.out_bit    = r_out_bit;
  assign bus.out_valid  = r_out_valid;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// tb/tb_pixel_frame_ctrl.sv - directed vector bench for pixel_frame_ctrl
module tb_pixel_frame_ctrl;
  import pixel_ctrl_pkg::*;

  typedef struct {
    logic [7:0] et;
    logic [7:0] pat;
    logic [7:0] stream;
    int         mode;     // 0: ready high, 1: random ready + long stall at idx 3, 2: start pulsed while busy
    int         done_at;  // edge index of frame_done after the start edge, -1 = not checked
    int         sen;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pat = 8'h00;
  int         n_checks = 0;
  int         n_err = 0;
  vec_t       vecs[6];

  always #5 clk = ~clk;

  pixel_frame_ctrl_if #(.SEL_W(DEF_SEL_W), .EXP_W(DEF_EXP_W)) bus();

  assign bus.pix_mux_out = pat[bus.rd_sel];

  pixel_frame_ctrl #(
    .NPIX(DEF_NPIX), .SEL_W(DEF_SEL_W), .EXP_W(DEF_EXP_W), .CLR_CYC(DEF_CLR_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return 32'({bus.pix_r, bus.pix_s_en, bus.rd_sel, bus.out_bit,
                bus.out_valid, bus.busy, bus.frame_done});
  endfunction

  task automatic run_frame(input int vi, input vec_t v);
    int         edge_n, n_hs, n_r, n_sen, n_done, done_at, stall_bad, stall_cnt, order_bad;
    logic [7:0] got;
    logic       seen, ok_end, pv, pr, pb;
    logic [2:0] ps;
    n_hs = 0; n_r = 0; n_sen = 0; n_done = 0; done_at = -1;
    stall_bad = 0; stall_cnt = 0; order_bad = 0;
    got = 8'h00; seen = 1'b0; ok_end = 1'b0;
    pv = 1'b0; pr = 1'b0; pb = 1'b0; ps = 3'd0;
    pat = v.pat;
    bus.start = 1'b1; bus.exp_time = v.et; bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0;
    bus.exp_time = ~v.et;
    edge_n = 0;
    while (edge_n < 400) begin
      if (pv && !pr) begin
        if (!(bus.out_valid && bus.out_bit == pb && bus.rd_sel == ps)) stall_bad++;
      end
      if (bus.pix_r) n_r++;
      if (bus.pix_s_en) n_sen++;
      if (bus.frame_done) begin
        n_done++;
        done_at = edge_n;
        seen = 1'b1;
      end
      if (seen && !bus.busy) begin
        ok_end = 1'b1;
        break;
      end
      if (v.mode == 1) begin
        if (bus.out_valid && bus.rd_sel == 3'd3 && stall_cnt < 20) begin
          bus.out_ready = 1'b0;
          stall_cnt++;
        end else begin
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end else begin
        bus.out_ready = 1'b1;
      end
      bus.start = (v.mode == 2) && (bus.pix_s_en || bus.out_valid);
      if (bus.out_valid && bus.out_ready) begin
        got[bus.rd_sel] = bus.out_bit;
        if (32'(bus.rd_sel) != 32'(n_hs)) order_bad++;
        n_hs++;
      end
      pv = bus.out_valid; pr = bus.out_ready; pb = bus.out_bit; ps = bus.rd_sel;
      step();
      edge_n++;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    chk($sformatf("v%0d_end_in_budget", vi), 32'(ok_end), 32'd1);
    chk($sformatf("v%0d_handshakes", vi), 32'(n_hs), 32'd8);
    chk($sformatf("v%0d_bits", vi), 32'(got), 32'(v.stream));
    chk($sformatf("v%0d_order", vi), 32'(order_bad), 32'd0);
    chk($sformatf("v%0d_clear_cycles", vi), 32'(n_r), 32'd2);
    chk($sformatf("v%0d_expose_cycles", vi), 32'(n_sen), 32'(v.sen));
    chk($sformatf("v%0d_done_pulses", vi), 32'(n_done), 32'd1);
    chk($sformatf("v%0d_stall_stable", vi), 32'(stall_bad), 32'd0);
    chk($sformatf("v%0d_idle_outputs", vi), all_out(), 32'd0);
    if (v.done_at >= 0) chk($sformatf("v%0d_done_edge", vi), 32'(done_at), 32'(v.done_at));
    if (v.mode == 1) chk($sformatf("v%0d_stall_seen", vi), 32'(stall_cnt), 32'd20);
  endtask

  initial begin
    int cnt;
    int k;
    vecs[0] = '{8'd5,  8'hB2, 8'hB2, 0, 23, 5};
    vecs[1] = '{8'd0,  8'h5A, 8'h5A, 0, 18, 0};
    vecs[2] = '{8'd1,  8'hFF, 8'hFF, 2, 19, 1};
    vecs[3] = '{8'd3,  8'h00, 8'h00, 0, 21, 3};
    vecs[4] = '{8'd12, 8'h81, 8'h81, 1, -1, 12};
    vecs[5] = '{8'd7,  8'h6C, 8'h6C, 2, 25, 7};

    bus.start = 1'b1; bus.exp_time = 8'd9; bus.out_ready = 1'b0;
    reset = 1'b0;
    repeat (3) step();
    chk("reset_outputs", all_out(), 32'd0);
    bus.start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("idle_cycle%0d", i), all_out(), 32'd0);
    end

    for (int i = 0; i < 6; i++) run_frame(i, vecs[i]);

    // start held high: back-to-back frames, second uses exp_time present in the IDLE cycle
    pat = 8'hC3;
    bus.start = 1'b1; bus.exp_time = 8'd4; bus.out_ready = 1'b1;
    step();
    bus.exp_time = 8'd9;
    cnt = 0; k = 0;
    while (!bus.frame_done && k < 200) begin
      if (bus.pix_s_en) cnt++;
      step();
      k++;
    end
    chk("held_first_done_seen", 32'(bus.frame_done), 32'd1);
    chk("held_first_exposure", 32'(cnt), 32'd4);
    bus.exp_time = 8'd2;
    step();
    chk("held_idle_gap", all_out(), 32'd0);
    step();
    chk("held_restart_clear", 32'(bus.pix_r && bus.busy), 32'd1);
    bus.start = 1'b0;
    bus.exp_time = 8'd0;
    cnt = 0; k = 0;
    while (!bus.frame_done && k < 200) begin
      if (bus.pix_s_en) cnt++;
      step();
      k++;
    end
    chk("held_second_done_seen", 32'(bus.frame_done), 32'd1);
    chk("held_second_exposure", 32'(cnt), 32'd2);
    step();
    chk("held_second_idle", all_out(), 32'd0);

    // reset in SHIFT at idx 5, then a clean full frame
    pat = 8'hB2;
    bus.start = 1'b1; bus.exp_time = 8'd1; bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0;
    k = 0;
    while (!(bus.out_valid && bus.rd_sel == 3'd5) && k < 200) begin
      step();
      k++;
    end
    chk("mreset_reached_idx5", 32'(bus.out_valid && bus.rd_sel == 3'd5), 32'd1);
    reset = 1'b0;
    step();
    chk("mreset_outputs_zero", all_out(), 32'd0);
    reset = 1'b1;
    step();
    chk("mreset_stays_idle", all_out(), 32'd0);
    run_frame(6, vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
